// File: rtl/instruction_fetch.sv
// Fetch sequencer: owns the program counter, issues one-cycle read requests to instruction
// memory, captures the returned word and strobes it into the instruction latch, then waits
// for the consumer to advance (i_next) or redirect (i_jump) before fetching again.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_next,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_latch_enable,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy,
  output logic                  o_fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last WAIT count value before the timeout fires; WAIT lasts TIMEOUT cycles without valid.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StPresent, StHold} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic                  mem_rd_q, latch_en_q, busy_q;

  // Next-state, PC, captured word, timeout counter and sticky fault.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (i_jump) begin
          pc_d = i_jump_addr;
        end else if (i_run) begin
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (i_mem_valid) begin
          instr_d = i_mem_data;
          state_d = StPresent;
        end else if (cnt_q == CntLast) begin
          // Memory never answered: flag it and reissue the request for the same PC.
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPresent: begin
        state_d = StHold;
      end
      StHold: begin
        if (i_jump) begin
          pc_d    = i_jump_addr;
          state_d = i_run ? StReq : StIdle;
        end else if (i_next) begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = i_run ? StReq : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; strobes and busy are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      latch_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      mem_rd_q   <= (state_d == StReq);
      latch_en_q <= (state_d == StPresent);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign o_mem_addr     = pc_q;
  assign o_pc           = pc_q;
  assign o_mem_rd       = mem_rd_q;
  assign o_instr        = instr_q;
  assign o_latch_enable = latch_en_q;
  assign o_busy         = busy_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level memory/consumer model.
module tb_instruction_fetch;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, nxt, jump, mvalid;
  logic [7:0] jaddr, mdata;
  logic [7:0] mem_addr, instr, pc;
  logic       mem_rd, le, busy, fault;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .RESET_PC  (8'h00),
    .TIMEOUT   (15)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_run         (run),
    .i_next        (nxt),
    .i_jump        (jump),
    .i_jump_addr   (jaddr),
    .o_mem_addr    (mem_addr),
    .o_mem_rd      (mem_rd),
    .i_mem_data    (mdata),
    .i_mem_valid   (mvalid),
    .o_instr       (instr),
    .o_latch_enable(le),
    .o_pc          (pc),
    .o_busy        (busy),
    .o_fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run, nxt, jump;
    logic [7:0] jaddr;
    logic       valid;
    logic [7:0] data;
    logic       e_rd, e_le, e_busy;
    logic [7:0] e_pc, e_instr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run = L; nxt = L; jump = L; jaddr = 8'h00; mvalid = L; mdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = L;
    repeat (2) @(posedge clk);
    #3 rst_n = H;
    cyc();
  endtask

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return (a * 8'd7) + 8'h3C;
  endfunction

  int         waits, strobes, idx, dly, hcnt, n_rd, n_le;
  bit         saw_rd, fault_early, rd_last, pend, in_hold, idle, exp_le;
  logic [7:0] last_addr, req_addr, exp_pc;

  initial begin
    // {run, next, jump, jaddr, valid, data} -> {rd, le, busy, pc, instr}
    vecs[0]  = '{H, L, L, 8'h00, L, 8'h00, H, L, H, 8'h00, 8'h00};
    vecs[1]  = '{H, L, L, 8'h00, L, 8'h00, L, L, H, 8'h00, 8'h00};
    vecs[2]  = '{L, L, L, 8'h00, H, 8'hA5, L, H, H, 8'h00, 8'hA5};
    vecs[3]  = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'h00, 8'hA5};
    vecs[4]  = '{H, L, L, 8'h00, L, 8'h00, L, L, H, 8'h00, 8'hA5};
    vecs[5]  = '{H, H, L, 8'h00, L, 8'h00, H, L, H, 8'h01, 8'hA5};
    vecs[6]  = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'h01, 8'hA5};
    vecs[7]  = '{L, L, L, 8'h00, H, 8'h3C, L, H, H, 8'h01, 8'h3C};
    vecs[8]  = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'h01, 8'h3C};
    vecs[9]  = '{L, H, H, 8'h40, L, 8'h00, L, L, L, 8'h40, 8'h3C};
    vecs[10] = '{H, L, H, 8'hFF, L, 8'h00, L, L, L, 8'hFF, 8'h3C};
    vecs[11] = '{H, L, L, 8'h00, L, 8'h00, H, L, H, 8'hFF, 8'h3C};
    vecs[12] = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'hFF, 8'h3C};
    vecs[13] = '{L, L, L, 8'h00, H, 8'h77, L, H, H, 8'hFF, 8'h77};
    vecs[14] = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'hFF, 8'h77};
    vecs[15] = '{H, H, L, 8'h00, L, 8'h00, H, L, H, 8'h00, 8'h77};
    vecs[16] = '{L, L, L, 8'h00, H, 8'hEE, L, L, H, 8'h00, 8'h77};
    vecs[17] = '{L, L, L, 8'h00, H, 8'h11, L, H, H, 8'h00, 8'h11};
    vecs[18] = '{L, H, L, 8'h00, L, 8'h00, L, L, H, 8'h00, 8'h11};
    vecs[19] = '{H, H, H, 8'h40, L, 8'h00, H, L, H, 8'h40, 8'h11};
    vecs[20] = '{L, L, L, 8'h00, L, 8'h00, L, L, H, 8'h40, 8'h11};

    // Reset values, checked while reset is still asserted.
    idle_inputs();
    rst_n = L;
    #12;
    chk("rst_rd", 32'(mem_rd), 32'(L));
    chk("rst_le", 32'(le), 32'(L));
    chk("rst_busy", 32'(busy), 32'(L));
    chk("rst_fault", 32'(fault), 32'(L));
    chk("rst_instr", 32'(instr), 32'h00);
    chk("rst_pc", 32'(pc), 32'h00);
    #3 rst_n = H;
    cyc();

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      run = vecs[i].run; nxt = vecs[i].nxt; jump = vecs[i].jump; jaddr = vecs[i].jaddr;
      mvalid = vecs[i].valid; mdata = vecs[i].data;
      cyc();
      chk($sformatf("vec%0d_rd", i), 32'(mem_rd), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_le", i), 32'(le), 32'(vecs[i].e_le));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(L));
    end

    // Continuous run with i_next held: memory returns addr^FF one cycle after the request.
    do_reset();
    run = H; nxt = H;
    rd_last = 0; strobes = 0; idx = 0; last_addr = 8'h00;
    for (int c = 0; c < 80 && strobes < 6; c++) begin
      cyc();
      if (le) begin
        chk("seq_instr", 32'(instr), 32'(8'(idx) ^ 8'hFF));
        chk("seq_pc", 32'(pc), 32'(idx));
        strobes++;
        idx++;
      end
      mvalid = rd_last;
      mdata  = last_addr ^ 8'hFF;
      rd_last = mem_rd;
      if (mem_rd) last_addr = mem_addr;
    end
    chk("seq_strobes", 32'(strobes), 32'd6);
    idle_inputs();

    // Timeout: no valid for 15 WAIT cycles -> fault and refetch of the same address.
    do_reset();
    jump = H; jaddr = 8'h55;
    cyc();
    idle_inputs();
    run = H;
    cyc();
    chk("to_req_rd", 32'(mem_rd), 32'(H));
    chk("to_req_addr", 32'(mem_addr), 32'h55);
    waits = 0; saw_rd = 0; fault_early = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (mem_rd) begin
        saw_rd = 1;
        break;
      end
      if (fault) fault_early = 1;
      waits++;
    end
    chk("to_reissue", 32'(saw_rd), 32'd1);
    chk("to_wait_cycles", 32'(waits), 32'd15);
    chk("to_fault_early", 32'(fault_early), 32'd0);
    chk("to_fault", 32'(fault), 32'(H));
    chk("to_addr", 32'(mem_addr), 32'h55);
    cyc();
    mvalid = H; mdata = 8'h5A;
    cyc();
    idle_inputs();
    chk("to_le", 32'(le), 32'(H));
    chk("to_instr", 32'(instr), 32'h5A);
    cyc();
    chk("to_le_pulse", 32'(le), 32'(L));
    chk("to_fault_sticky", 32'(fault), 32'(H));

    // Reset in the middle of WAIT, then a late memory response.
    do_reset();
    jump = H; jaddr = 8'h20;
    cyc();
    idle_inputs();
    run = H;
    cyc();
    run = L;
    cyc();
    chk("mr_wait_busy", 32'(busy), 32'(H));
    chk("mr_wait_pc", 32'(pc), 32'h20);
    #2 rst_n = L;
    #1;
    chk("mr_async_busy", 32'(busy), 32'(L));
    chk("mr_async_pc", 32'(pc), 32'h00);
    @(posedge clk);
    #3 rst_n = H;
    mvalid = H; mdata = 8'h99;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("mr_no_strobe", 32'(le), 32'(L));
    end
    idle_inputs();
    chk("mr_instr", 32'(instr), 32'h00);
    chk("mr_pc", 32'(pc), 32'h00);
    chk("mr_busy", 32'(busy), 32'(L));
    chk("mr_fault", 32'(fault), 32'(L));

    // Randomized run against a transaction-level model of memory and consumer.
    do_reset();
    exp_pc = 8'h00; idle = 1; pend = 0; in_hold = 0; exp_le = 0;
    n_rd = 0; n_le = 0; dly = 0; hcnt = 0; req_addr = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      chk("rnd_le", 32'(le), 32'(exp_le));
      if (mem_rd) begin
        chk("rnd_addr", 32'(mem_addr), 32'(exp_pc));
        n_rd++;
      end
      if (le) begin
        chk("rnd_instr", 32'(instr), 32'(mem_fn(exp_pc)));
        chk("rnd_pc", 32'(pc), 32'(exp_pc));
        n_le++;
      end
      idle_inputs();
      jaddr = 8'($urandom);
      mdata = 8'($urandom);
      exp_le = 0;
      // Memory side: answer each request after 1..4 WAIT cycles; stray valids otherwise.
      if (mem_rd) begin
        pend = 1;
        dly = $urandom_range(1, 4);
        req_addr = mem_addr;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin
          mvalid = H;
          mdata = mem_fn(req_addr);
          pend = 0;
          exp_le = 1;
        end
      end else begin
        mvalid = ($urandom_range(0, 7) == 0);
      end
      // Consumer side.
      if (le) begin
        in_hold = 1;
        hcnt = $urandom_range(0, 3);
        nxt = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        run = 1'($urandom_range(0, 1));
      end else if (in_hold) begin
        if (hcnt > 0) begin
          hcnt--;
          run = 1'($urandom_range(0, 1));
        end else begin
          run = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 3) == 0) begin
            jump = H;
            nxt = 1'($urandom_range(0, 1));
            exp_pc = jaddr;
          end else begin
            nxt = H;
            exp_pc = exp_pc + 8'd1;
          end
          in_hold = 0;
          idle = !run;
        end
      end else if (idle) begin
        chk("rnd_idle_busy", 32'(busy), 32'(L));
        if ($urandom_range(0, 2) == 0) begin
          jump = H;
          run = 1'($urandom_range(0, 1));
          exp_pc = jaddr;
        end else begin
          run = H;
          idle = 0;
        end
      end
    end
    chk("rnd_strobe_count", 32'(n_le), 32'(n_rd - ((pend || exp_le) ? 1 : 0)));
    chk("rnd_fault", 32'(fault), 32'(L));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
